// File: rtl/multi_race_arbiter.sv
// multi_race_arbiter: per-channel race between two asynchronous arrival paths,
// decided over a bounded window and returned through a valid/ready handshake.
module multi_race_arbiter #(
   parameter int N_CH        = 8,
   parameter int TIMEOUT_CYC = 200,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N_CH-1:0]   finished_a,
   input  logic [N_CH-1:0]   finished_b,
   output logic              busy,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [N_CH-1:0]   response,
   output logic [N_CH-1:0]   tie,
   output logic [N_CH-1:0]   timeout,
   output logic [CNT_W-1:0]  race_cycles
);
   typedef enum logic [1:0] {IDLE, RACE, DONE} state_t;
   localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT_CYC);
   state_t state_q, state_d;
   logic [N_CH-1:0] a_meta_q, a_meta_d, a_sync_q, a_sync_d;
   logic [N_CH-1:0] b_meta_q, b_meta_d, b_sync_q, b_sync_d;
   logic [N_CH-1:0] dec_q, dec_d, resp_q, resp_d, tie_q, tie_d, to_q, to_d;
   logic [N_CH-1:0] newly;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      a_meta_d = finished_a;
      a_sync_d = a_meta_q;
      b_meta_d = finished_b;
      b_sync_d = b_meta_q;
      state_d  = state_q;
      dec_d    = dec_q;
      resp_d   = resp_q;
      tie_d    = tie_q;
      to_d     = to_q;
      cnt_d    = cnt_q;
      newly    = '0;
      case (state_q)
         IDLE: if (start) begin
            dec_d   = '0;
            resp_d  = '0;
            tie_d   = '0;
            to_d    = '0;
            cnt_d   = '0;
            state_d = RACE;
         end
         RACE: begin
            cnt_d  = (cnt_q == T_MAX) ? cnt_q : cnt_q + 1'b1;
            newly  = ~dec_q & (a_sync_q | b_sync_q);
            resp_d = resp_q | (newly & a_sync_q);
            tie_d  = tie_q | (newly & a_sync_q & b_sync_q);
            dec_d  = dec_q | newly;
            // decisions taken this cycle count before the timeout sweeps the rest
            if (&dec_d) state_d = DONE;
            else if (cnt_d == T_MAX) begin
               to_d    = ~dec_d;
               dec_d   = '1;
               state_d = DONE;
            end
         end
         DONE: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_meta_q <= '0;
         a_sync_q <= '0;
         b_meta_q <= '0;
         b_sync_q <= '0;
         dec_q    <= '0;
         resp_q   <= '0;
         tie_q    <= '0;
         to_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_meta_q <= a_meta_d;
         a_sync_q <= a_sync_d;
         b_meta_q <= b_meta_d;
         b_sync_q <= b_sync_d;
         dec_q    <= dec_d;
         resp_q   <= resp_d;
         tie_q    <= tie_d;
         to_q     <= to_d;
         cnt_q    <= cnt_d;
      end
   end
   assign busy        = state_q != IDLE;
   assign resp_valid  = state_q == DONE;
   assign response    = resp_q;
   assign tie         = tie_q;
   assign timeout     = to_q;
   assign race_cycles = cnt_q;
endmodule

// File: tb/tb_multi_race_arbiter.sv
// tb_multi_race_arbiter: table-driven races with a scoreboard of expected results,
// plus reset and abort sequences.
module tb_multi_race_arbiter;
   logic clk, rst_n, start, resp_ready, busy, resp_valid;
   logic [3:0] finished_a, finished_b, response, tie, timeout;
   logic [15:0] race_cycles;
   int errors = 0, checks = 0;
   typedef struct {
      logic [3:0] a1, b1; int c1;
      logic [3:0] a2, b2; int c2;
      bit tgl, pre; int stall;
      logic [3:0] resp, tie, to; int rc;
   } vec_t;
   typedef struct { logic [3:0] resp, tie, to; int rc; } exp_t;
   vec_t vt[10];
   exp_t sb[$];

   multi_race_arbiter #(.N_CH(4), .TIMEOUT_CYC(10), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .finished_a(finished_a),
      .finished_b(finished_b), .busy(busy), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .response(response), .tie(tie),
      .timeout(timeout), .race_cycles(race_cycles));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pop_check(input int idx);
      exp_t e;
      for (int i = 0; i < 40 && !resp_valid; i++) @(negedge clk);
      if (!resp_valid) chk($sformatf("v%0d_resp_valid_wait", idx), 0, 1);
      else if (sb.size() == 0) chk($sformatf("v%0d_sb_empty", idx), 0, 1);
      else begin
         e = sb.pop_front();
         chk($sformatf("v%0d_response", idx), response, e.resp);
         chk($sformatf("v%0d_tie", idx), tie, e.tie);
         chk($sformatf("v%0d_timeout", idx), timeout, e.to);
         chk($sformatf("v%0d_race_cycles", idx), race_cycles, e.rc);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      if (v.pre) begin
         finished_a = v.a1;
         finished_b = v.b1;
         repeat (3) @(negedge clk);
      end
      sb.push_back('{v.resp, v.tie, v.to, v.rc});
      resp_ready = (v.stall == 0);
      start = 1;
      @(negedge clk);
      start = 0;
      chk($sformatf("v%0d_busy_after_start", idx), busy, 1);
      for (int c = 1; c <= 12; c++) begin
         if (c == v.c1) begin finished_a |= v.a1; finished_b |= v.b1; end
         if (c == v.c2) begin finished_a |= v.a2; finished_b |= v.b2; end
         if (v.tgl && c > 3) begin
            finished_a[0] = 1'($urandom);
            finished_b[0] = 1'($urandom);
         end
         @(negedge clk);
         if (resp_valid) break;
      end
      for (int k = 0; k < v.stall; k++) begin
         start = (k % 2 == 0);
         chk($sformatf("v%0d_stall_valid", idx), resp_valid, 1);
         chk($sformatf("v%0d_stall_busy", idx), busy, 1);
         chk($sformatf("v%0d_stall_response", idx), response, v.resp);
         @(negedge clk);
      end
      start = 0;
      resp_ready = 1;
      pop_check(idx);
      @(negedge clk);
      chk($sformatf("v%0d_valid_dropped", idx), resp_valid, 0);
      chk($sformatf("v%0d_busy_dropped", idx), busy, 0);
      finished_a = 0;
      finished_b = 0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      vt[0] = '{4'b0101, 4'b0110, 5, 4'b1000, 4'b0000, 8, 0, 0, 0,  4'b1101, 4'b0100, 4'b0000, 10};
      vt[1] = '{4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0,  4'b0001, 4'b0000, 4'b1110, 10};
      vt[2] = '{4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 0, 0,  4'b0000, 4'b0000, 4'b0000, 3};
      vt[3] = '{4'b1111, 4'b1111, 2, 4'b0000, 4'b0000, 0, 0, 0, 0,  4'b1111, 4'b1111, 4'b0000, 4};
      vt[4] = '{4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  4'b0000, 4'b0000, 4'b1111, 10};
      vt[5] = '{4'b0011, 4'b0000, 1, 4'b0000, 4'b1100, 6, 0, 0, 20, 4'b0011, 4'b0000, 4'b0000, 8};
      vt[6] = '{4'b0000, 4'b0001, 1, 4'b1111, 4'b0000, 3, 0, 0, 0,  4'b1110, 4'b0000, 4'b0000, 5};
      vt[7] = '{4'b1111, 4'b0000, 9, 4'b0000, 4'b0000, 0, 0, 0, 0,  4'b0000, 4'b0000, 4'b1111, 10};
      vt[8] = '{4'b0000, 4'b0001, 1, 4'b0000, 4'b0000, 0, 1, 0, 0,  4'b0000, 4'b0000, 4'b1110, 10};
      vt[9] = '{4'b1111, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 1, 0,  4'b1111, 4'b0000, 4'b0000, 1};
      rst_n = 0; start = 0; resp_ready = 1; finished_a = 0; finished_b = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_response", response, 0);
      chk("rst_tie", tie, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_race_cycles", race_cycles, 0);
      rst_n = 1;
      for (int i = 0; i < 10; i++) run_vec(i, vt[i]);
      // abort a race part-way with an asynchronous reset, then restart immediately
      finished_a = 4'b0011;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      chk("abort_pre_busy", busy, 1);
      chk("abort_pre_response", response, 4'b0011);
      #2 rst_n = 0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_resp_valid", resp_valid, 0);
      chk("abort_response", response, 0);
      chk("abort_timeout", timeout, 0);
      chk("abort_race_cycles", race_cycles, 0);
      finished_a = 0;
      repeat (2) @(negedge clk);
      chk("abort_held_valid", resp_valid, 0);
      rst_n = 1;
      run_vec(10, vt[2]);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
